// File: rtl/time_setter_pkg.sv
// time_setter_pkg
// Shared definitions for the operator-side time entry block:
//   - state_t      : controller state encoding (also exported for debug)
//   - DIG_*        : digit index constants, same encoding as the display selector
//   - UNIT_MAX/TENS_MAX : legal upper bound of unit and tens digits
//   - incDigit()   : wrap-around BCD increment of one preset digit
package time_setter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EDIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] DIG_US = 2'd0;
  localparam logic [1:0] DIG_DS = 2'd1;
  localparam logic [1:0] DIG_UM = 2'd2;
  localparam logic [1:0] DIG_DM = 2'd3;

  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Tens digits (DS, DM) wrap 5->0, unit digits (US, UM) wrap 9->0.
  // The >= comparison keeps the result legal even for an out-of-range input.
  function automatic logic [3:0] incDigit(input logic [1:0] idx, input logic [3:0] val);
    logic [3:0] lim;
    lim = ((idx == DIG_DS) || (idx == DIG_DM)) ? TENS_MAX : UNIT_MAX;
    return (val >= lim) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge
// Registered rising-edge detector for one push-button level.
//   clk   : sampling clock
//   rst   : asynchronous active-high reset (clears the stored sample)
//   level : button level, synchronous to clk
//   rise  : high while level=1 and the previous registered sample was 0
// rise is combinational from level and the stored sample, so the consumer acts
// on the same clock edge that stores the new sample; a held button acts once.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prevLevel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prevLevel <= 1'b0;
    else     prevLevel <= level;
  end

  assign rise = level & ~prevLevel;

endmodule

// File: rtl/time_setter.sv
// time_setter
// Front-panel time entry and run control for the MM:SS countdown timer.
// Edits four BCD preset digits from push buttons, loads them into the timer
// and watches the timer's stop flag to report completion.
//   new_clock, reset        : clock (rising edge) / async active-high reset
//   btn_inc/next/start/cancel : button levels, edge detected internally
//   timer_stop              : timer reads 00:00
//   preset_us/ds/um/dm      : registered BCD preset digits
//   load, clear             : one-cycle command pulses to the timer
//   run                     : timer count enable
//   done                    : countdown finished (level)
//   edit_digit              : digit under edit, 0=US 1=DS 2=UM 3=DM
//   blank                   : one-hot blink mask of the edited digit
//   dbgState                : current controller state
//
// Timer interface protocol: load and clear are fire-and-forget strobes, each
// valid for exactly one cycle with no ready/backpressure; the timer must
// accept them in that cycle. The preset digits are stable whenever load=1
// and stay stable through LOAD/RUN/DONE.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int BLINK_DIV = 250,
  parameter int HOLDOFF   = 2
) (
  input  logic       new_clock,
  input  logic       reset,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_start,
  input  logic       btn_cancel,
  input  logic       timer_stop,
  output logic [3:0] preset_us,
  output logic [3:0] preset_ds,
  output logic [3:0] preset_um,
  output logic [3:0] preset_dm,
  output logic       load,
  output logic       clear,
  output logic       run,
  output logic       done,
  output logic [1:0] edit_digit,
  output logic [3:0] blank,
  output state_t     dbgState
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic incEdge, nextEdge, startEdge, cancelEdge;

  btn_edge uIncEdge    (.clk(new_clock), .rst(reset), .level(btn_inc),    .rise(incEdge));
  btn_edge uNextEdge   (.clk(new_clock), .rst(reset), .level(btn_next),   .rise(nextEdge));
  btn_edge uStartEdge  (.clk(new_clock), .rst(reset), .level(btn_start),  .rise(startEdge));
  btn_edge uCancelEdge (.clk(new_clock), .rst(reset), .level(btn_cancel), .rise(cancelEdge));

  state_t          state, stateNext;
  logic [3:0][3:0] digits, digitsNext;   // indexed by DIG_*
  logic [1:0]      editDigit, editNext;
  logic            clearReg, clearNext;
  logic [HW-1:0]   holdCnt, holdNext;
  logic            blinkRestart;
  logic [BW-1:0]   blinkCnt;
  logic            blinkPhase;
  logic            anyNonzero;

  assign anyNonzero = |digits;

  always_ff @(posedge new_clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      digits    <= '0;
      editDigit <= DIG_US;
      clearReg  <= 1'b0;
      holdCnt   <= '0;
    end else begin
      state     <= stateNext;
      digits    <= digitsNext;
      editDigit <= editNext;
      clearReg  <= clearNext;
      holdCnt   <= holdNext;
    end
  end

  // Each state branch walks the button edges in priority order
  // cancel > start > next > inc, so only the highest edge acts.
  always_comb begin
    stateNext    = state;
    digitsNext   = digits;
    editNext     = editDigit;
    clearNext    = 1'b0;
    holdNext     = holdCnt;
    blinkRestart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cancelEdge) begin
          digitsNext = '0;
          clearNext  = 1'b1;
        end else if (startEdge) begin
          if (anyNonzero) stateNext = ST_LOAD;
        end else if (nextEdge) begin
          stateNext    = ST_EDIT;
          editNext     = DIG_US;
          blinkRestart = 1'b1;
        end
      end
      ST_EDIT: begin
        if (cancelEdge) begin
          stateNext  = ST_IDLE;
          digitsNext = '0;
          clearNext  = 1'b1;
        end else if (startEdge) begin
          if (anyNonzero) stateNext = ST_LOAD;
        end else if (nextEdge) begin
          // 2-bit index wraps DM -> US, which is also the reset value.
          editNext     = editDigit + 2'd1;
          blinkRestart = 1'b1;
          if (editDigit == DIG_DM) stateNext = ST_IDLE;
        end else if (incEdge) begin
          digitsNext[editDigit] = incDigit(editDigit, digits[editDigit]);
          blinkRestart          = 1'b1;
        end
      end
      ST_LOAD: begin
        stateNext = ST_RUN;
        holdNext  = '0;
      end
      ST_RUN: begin
        // The timer may still show the previous 00:00 right after a load,
        // so the stop flag is masked for the first HOLDOFF RUN cycles.
        if (cancelEdge) begin
          stateNext = ST_IDLE;
          clearNext = 1'b1;
        end else if (holdCnt < HW'(HOLDOFF)) begin
          holdNext = holdCnt + 1'b1;
        end else if (timer_stop) begin
          stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cancelEdge) begin
          stateNext = ST_IDLE;
          clearNext = 1'b1;
        end else if (startEdge) begin
          stateNext = ST_LOAD;
        end else if (nextEdge) begin
          stateNext    = ST_EDIT;
          editNext     = DIG_US;
          blinkRestart = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Blink timebase: restarting on every edit action keeps the freshly
  // changed digit visible for a full half-period.
  always_ff @(posedge new_clock or posedge reset) begin
    if (reset) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (blinkRestart || (state != ST_EDIT)) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (blinkCnt == BW'(BLINK_DIV - 1)) begin
      blinkCnt   <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
    end
  end

  assign preset_us  = digits[DIG_US];
  assign preset_ds  = digits[DIG_DS];
  assign preset_um  = digits[DIG_UM];
  assign preset_dm  = digits[DIG_DM];
  assign load       = (state == ST_LOAD);
  assign run        = (state == ST_RUN);
  assign done       = (state == ST_DONE);
  assign clear      = clearReg;
  assign edit_digit = editDigit;
  assign blank      = ((state == ST_EDIT) && blinkPhase) ? (4'b0001 << editDigit) : 4'b0000;
  assign dbgState   = state;

endmodule
